// File: rtl/bl_row_scheduler.sv
// Backlight row scheduler: tracks lines since VSYNC and streams each row's duty words to the LED driver.
// Optional BL_OVERRUN_CNT_EN adds a saturating overrun event counter (oOverrun_cnt).
module bl_row_scheduler #(
  parameter int V_START   = 37,
  parameter int ROW_LINES = 72,
  parameter int ROWS      = 15,
  parameter int COLS      = 16,
  parameter int DW        = 8,
  parameter int AW        = 8
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iHSYNC,
  input  logic          iVSYNC,
  output logic [11:0]   oLine,
  output logic [3:0]    oRow,
  output logic [6:0]    oBlock_line,
  output logic          oRow_active,
  output logic          oRam_rd,
  output logic [AW-1:0] oRam_addr,
  input  logic [DW-1:0] iRam_data,
  output logic [DW-1:0] oDuty,
  output logic          oDuty_valid,
  input  logic          iDrv_ready,
  output logic          oLatch,
  output logic          oOverrun
`ifdef BL_OVERRUN_CNT_EN
  , output logic [7:0]  oOverrun_cnt
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, LATCH} stateT;

  stateT         state;
  logic [CW-1:0] col;
  logic          framed;
  logic [11:0]   lineNext;
  logic          hsOnly;
  logic          rowEndLine;
  logic          startFirst;
  logic          startNext;
  logic          frameEnd;
  logic          rowStart;
  logic [3:0]    rowNew;

  function automatic logic [AW-1:0] addrOf(input logic [3:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  // Row boundaries are found by counting lines inside the row rather than comparing against every row start.
  always_comb begin
    lineNext   = (oLine == 12'hFFF) ? oLine : oLine + 12'd1;
    hsOnly     = iHSYNC && !iVSYNC;
    rowEndLine = oRow_active && (oBlock_line == 7'(ROW_LINES - 1));
    startFirst = hsOnly && framed && !oRow_active && (lineNext == 12'(V_START));
    startNext  = hsOnly && rowEndLine && (oRow < 4'(ROWS - 1));
    frameEnd   = hsOnly && rowEndLine && (oRow == 4'(ROWS - 1));
    rowStart   = startFirst || startNext;
    rowNew     = startFirst ? 4'd0 : oRow + 4'd1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oLine       <= '0;
      oRow        <= '0;
      oBlock_line <= '0;
      oRow_active <= 1'b0;
      framed      <= 1'b0;
    end else if (iVSYNC) begin
      oLine       <= '0;
      oRow        <= '0;
      oBlock_line <= '0;
      oRow_active <= 1'b0;
      framed      <= 1'b1;
    end else if (iHSYNC) begin
      oLine <= lineNext;
      if (rowStart) begin
        oRow        <= rowNew;
        oBlock_line <= '0;
        oRow_active <= 1'b1;
      end else if (frameEnd) begin
        oRow_active <= 1'b0;
      end else if (oRow_active) begin
        oBlock_line <= oBlock_line + 7'd1;
      end
    end
  end

  // A row start always restarts the transfer; arriving outside IDLE flags an overrun.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= IDLE;
      col         <= '0;
      oRam_rd     <= 1'b0;
      oRam_addr   <= '0;
      oDuty       <= '0;
      oDuty_valid <= 1'b0;
      oLatch      <= 1'b0;
      oOverrun    <= 1'b0;
`ifdef BL_OVERRUN_CNT_EN
      oOverrun_cnt <= '0;
`endif
    end else if (iVSYNC) begin
      state       <= IDLE;
      col         <= '0;
      oRam_rd     <= 1'b0;
      oDuty_valid <= 1'b0;
      oLatch      <= 1'b0;
      oOverrun    <= 1'b0;
    end else if (rowStart) begin
      if (state != IDLE) begin
        oOverrun <= 1'b1;
`ifdef BL_OVERRUN_CNT_EN
        if (oOverrun_cnt != 8'hFF) oOverrun_cnt <= oOverrun_cnt + 8'd1;
`endif
      end
      state       <= READ;
      col         <= '0;
      oRam_rd     <= 1'b1;
      oRam_addr   <= addrOf(rowNew, '0);
      oDuty_valid <= 1'b0;
      oLatch      <= 1'b0;
    end else begin
      oRam_rd <= 1'b0;
      oLatch  <= 1'b0;
      case (state)
        IDLE: state <= IDLE;
        READ: state <= WAIT;
        WAIT: begin
          oDuty       <= iRam_data;
          oDuty_valid <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (iDrv_ready) begin
            oDuty_valid <= 1'b0;
            if (col < CW'(COLS - 1)) begin
              col       <= col + 1'b1;
              oRam_rd   <= 1'b1;
              oRam_addr <= addrOf(oRow, col + 1'b1);
              state     <= READ;
            end else begin
              oLatch <= 1'b1;
              state  <= LATCH;
            end
          end
        end
        LATCH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
